// File: rtl/sap_ram_loader.sv
// SAP-1 RAM arbiter and program loader: passes CPU strobes through when idle, otherwise streams bytes into RAM.
// Optional read-back check of each written byte is compiled in with SAP_LOADER_VERIFY_EN.
module sap_ram_loader #(
  parameter int         LOAD_WORDS = 16,
  parameter logic [3:0] BASE_ADDR  = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_start,
  input  logic       load_abort,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic       cpu_addr_en,
  input  logic       cpu_we,
  input  logic       cpu_oe,
  output logic       cpu_grant,
  output logic       ram_address_enable,
  output logic       ram_write_enable,
  output logic       ram_output_enable,
  output logic       bus_drive,
  output logic [7:0] bus_data,
  input  logic [7:0] ram_rd_data,
  output logic       busy,
  output logic       done,
  output logic       load_error
);

  localparam logic [3:0] LAST_ADDR = 4'(int'(BASE_ADDR) + LOAD_WORDS - 1);

`ifdef SAP_LOADER_VERIFY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WAIT_BYTE, S_WRITE, S_VERIFY, S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WAIT_BYTE, S_WRITE, S_DONE
  } state_t;
`endif

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_addr;
  logic [3:0] w_addr_next;
  logic [7:0] r_byte;
  logic [7:0] w_byte_next;
  logic       r_load_error;
  logic       w_load_error_next;

  logic       w_ldr_addr_en;
  logic       w_ldr_write_en;
  logic       w_ldr_drive;
  logic [7:0] w_ldr_data;
  logic       w_ldr_ready;
  logic       w_ldr_done;
  logic       w_last;

  assign w_last = (r_addr == LAST_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_addr       <= BASE_ADDR;
      r_byte       <= 8'h00;
      r_load_error <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_addr       <= w_addr_next;
      r_byte       <= w_byte_next;
      r_load_error <= w_load_error_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_addr_next       = r_addr;
    w_byte_next       = r_byte;
    w_load_error_next = r_load_error;
    w_ldr_addr_en     = 1'b0;
    w_ldr_write_en    = 1'b0;
    w_ldr_drive       = 1'b0;
    w_ldr_data        = 8'h00;
    w_ldr_ready       = 1'b0;
    w_ldr_done        = 1'b0;

    case (r_state)
      S_IDLE: begin
        // Abort outranks a simultaneous start request.
        if (load_start && !load_abort) begin
          w_state_next      = S_ADDR;
          w_addr_next       = BASE_ADDR;
          w_load_error_next = 1'b0;
        end
      end
      S_ADDR: begin
        w_ldr_addr_en = 1'b1;
        w_ldr_drive   = 1'b1;
        w_ldr_data    = {4'b0000, r_addr};
        w_state_next  = S_WAIT_BYTE;
      end
      S_WAIT_BYTE: begin
        w_ldr_ready = 1'b1;
        if (byte_valid) begin
          w_byte_next  = byte_data;
          w_state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        w_ldr_write_en = 1'b1;
        w_ldr_drive    = 1'b1;
        w_ldr_data     = r_byte;
`ifdef SAP_LOADER_VERIFY_EN
        w_state_next   = S_VERIFY;
`else
        if (w_last) begin
          w_state_next = S_DONE;
        end else begin
          w_addr_next  = r_addr + 4'd1;
          w_state_next = S_ADDR;
        end
`endif
      end
`ifdef SAP_LOADER_VERIFY_EN
      S_VERIFY: begin
        // RAM output reflects the word just written at the latched address.
        if (ram_rd_data != r_byte) begin
          w_load_error_next = 1'b1;
        end
        if (w_last) begin
          w_state_next = S_DONE;
        end else begin
          w_addr_next  = r_addr + 4'd1;
          w_state_next = S_ADDR;
        end
      end
`endif
      S_DONE: begin
        w_ldr_done   = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // A byte accepted in the abort cycle is dropped along with the load.
    if (load_abort && (r_state != S_IDLE)) begin
      w_state_next = S_IDLE;
      w_byte_next  = r_byte;
    end
  end

  assign cpu_grant          = (r_state == S_IDLE);
  assign busy               = !cpu_grant;
  assign byte_ready         = w_ldr_ready;
  assign done               = w_ldr_done;
  assign bus_drive          = w_ldr_drive;
  assign bus_data           = w_ldr_data;
  assign ram_address_enable = cpu_grant ? cpu_addr_en : w_ldr_addr_en;
  assign ram_write_enable   = cpu_grant ? cpu_we      : w_ldr_write_en;
  assign ram_output_enable  = cpu_grant & cpu_oe;

`ifdef SAP_LOADER_VERIFY_EN
  assign load_error = r_load_error;
`else
  logic w_unused_rd;
  assign w_unused_rd = ^{ram_rd_data, r_load_error, w_load_error_next};
  assign load_error  = 1'b0;
`endif

endmodule

// File: doc/sap_ram_loader.md
Name: sap_ram_loader

Overview:
Bus-owning program loader and arbiter for the SAP-1 16x8 RAM. In normal operation it passes the CPU controller's RAM strobes and bus drive straight through. On request it takes the RAM away from the CPU, then writes a stream of bytes into consecutive RAM addresses using the RAM's two-step protocol: address-latch cycle, then write cycle. It sits between the control sequencer, the byte source (switch panel / UART) and the RAM.

Parameters:
LOAD_WORDS, 16, number of bytes written per load (1..16)
BASE_ADDR, 0, first RAM address written (4 bits; BASE_ADDR+LOAD_WORDS <= 16)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
load_start  input  1  start-load request, sampled in IDLE only
load_abort  input  1  abandon load, return bus to CPU
byte_data  input  8  next program byte
byte_valid  input  1  byte_data valid
byte_ready  output  1  loader accepts byte this cycle
cpu_addr_en  input  1  CPU request: latch RAM address
cpu_we  input  1  CPU request: RAM write
cpu_oe  input  1  CPU request: RAM output enable
cpu_grant  output  1  1 = CPU owns RAM; CPU strobes passed through
ram_address_enable  output  1  to RAM address_enable
ram_write_enable  output  1  to RAM write_enable
ram_output_enable  output  1  to RAM output_enable
bus_drive  output  1  loader drives shared 8-bit bus this cycle
bus_data  output  8  value driven when bus_drive=1
ram_rd_data  input  8  RAM DATA_OUT (current-address contents)
busy  output  1  load in progress
done  output  1  one-cycle pulse, load completed
load_error  output  1  sticky verify mismatch (VERIFY build only)

Behaviour:
- Reset (async, rst_n=0): state IDLE, cpu_grant=1, busy=0, done=0, byte_ready=0, bus_drive=0, bus_data=0, load_error=0, address counter=BASE_ADDR.
- Mux: cpu_grant=1 -> ram_* = cpu_* combinationally, bus_drive=0. cpu_grant=0 -> ram_* from loader only; cpu_* ignored; ram_output_enable=0 always.
- States: IDLE, ADDR, WAIT_BYTE, WRITE, [VERIFY], DONE. cpu_grant = (state==IDLE); busy = !cpu_grant.
- IDLE: load_start=1 -> ADDR; address counter := BASE_ADDR.
- ADDR (1 cycle): ram_address_enable=1, bus_drive=1, bus_data={4'b0,addr}. Next state WAIT_BYTE.
- WAIT_BYTE: byte_ready=1. byte_valid=1 -> capture byte_data, go to WRITE. Otherwise hold, no timeout.
- WRITE (1 cycle): ram_write_enable=1, ram_address_enable=0, bus_drive=1, bus_data=captured byte.
  - Next state: VERIFY if built; otherwise DONE when addr==BASE_ADDR+LOAD_WORDS-1, else addr+1 and ADDR.
- DONE (1 cycle): done=1, next IDLE. Bus returns to the CPU on the following cycle.
- Timing: per-byte cost is 3 cycles plus byte wait (4 with VERIFY). Total load with byte_valid held high = 3*LOAD_WORDS+1 cycles from the load_start edge to done.
- The loader never asserts ram_address_enable and ram_write_enable together.
- load_abort=1 in any non-IDLE state -> IDLE next edge. No done pulse; any byte accepted that cycle is discarded; RAM contents already written stay.
- Simultaneous events:
  - load_start and load_abort together in IDLE: abort wins, stay IDLE.
  - load_start while busy: ignored.
- Address counter is 4 bits. No wrap occurs under legal parameters.
- load_error cleared only by reset or on entry to ADDR from IDLE.

Optional Feature:
SAP_LOADER_VERIFY_EN
- Defined: WRITE goes to VERIFY (1 cycle). In VERIFY, ram_rd_data is compared with the captured byte; a mismatch sets load_error (sticky). VERIFY then advances exactly as WRITE would without the feature. Total load time = 4*LOAD_WORDS+1 cycles.
- Undefined: no VERIFY state, ram_rd_data ignored, load_error tied 0.

Test Plan:
- Reset mid-load (after 5 bytes, rst_n=0) -> cpu_grant=1, busy=0, all ram_* loader strobes 0 immediately (async); first 5 RAM words hold written data.
- Full load, defaults, byte_valid always 1, bytes 0x10..0x1F -> RAM[0..15]=0x10..0x1F.
  - done pulses exactly 49 cycles after the load_start edge (65 with VERIFY); cpu_grant=0 throughout.
- Byte stall: byte_valid low 7 cycles at byte 3 -> FSM holds WAIT_BYTE, byte_ready=1, no RAM strobes; load resumes correctly.
- Pass-through: IDLE, cpu_addr_en=1 then cpu_oe=1 -> ram_address_enable, ram_output_enable mirror same cycle; during load, cpu_we=1 -> ram_write_enable follows loader only.
- Abort: load_abort at byte 8 WRITE -> IDLE next cycle, no done. New load_start with BASE_ADDR=4, LOAD_WORDS=2 writes RAM[4], RAM[5] only.
- VERIFY build: force ram_rd_data=0xFF while writing 0x3C -> load_error=1, stays 1 through done, cleared by next load_start.
